// File: rtl/rgmii_rx_decode.sv
// RGMII receive decoder: rebuilds a GMII byte stream from DDR sample pairs (1000M and 10/100M)
// and filters in-band link status. Define RGMII_RX_DECODE_STATS_EN to add frame/error counters.
module rgmii_rx_decode #(
    parameter int unsigned STATUS_FILTER = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rx_q1,
    input  logic [4:0] rx_q2,
    input  logic [1:0] speed,
    output logic [7:0] gmii_rxd,
    output logic       gmii_rx_dv,
    output logic       gmii_rx_er,
    output logic       gmii_clk_en,
    output logic       link_up,
    output logic [1:0] link_speed,
    output logic       link_duplex
`ifdef RGMII_RX_DECODE_STATS_EN
    ,
    output logic [15:0] frame_count,
    output logic [15:0] error_count
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    localparam logic [3:0] FILT = 4'(STATUS_FILTER);

    logic       dv, er, qual;
    logic       gig_q, gig_d;
    logic [1:0] state_q, state_d;
    logic [3:0] low_q, low_d;
    logic       low_er_q, low_er_d;
    logic       idle_ph_q, idle_ph_d;
    logic [7:0] rxd_q, rxd_d;
    logic       out_dv_q, out_dv_d;
    logic       out_er_q, out_er_d;
    logic       clk_en_q, clk_en_d;
    logic [3:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] link_q, link_d;

    assign dv   = rx_q1[4];
    assign er   = rx_q1[4] ^ rx_q2[4];
    assign qual = !dv && !er;

    always_comb begin
        gig_d     = gig_q;
        state_d   = state_q;
        low_d     = low_q;
        low_er_d  = low_er_q;
        idle_ph_d = idle_ph_q;
        rxd_d     = rxd_q;
        out_dv_d  = out_dv_q;
        out_er_d  = out_er_q;
        clk_en_d  = 1'b0;

        // Mode only changes between frames so a speed change never splits a frame.
        if (state_q == ST_IDLE && !dv) begin
            gig_d = (speed >= 2'b10);
        end

        if (gig_q) begin
            rxd_d    = {rx_q2[3:0], rx_q1[3:0]};
            out_dv_d = dv;
            out_er_d = er;
            clk_en_d = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (dv) begin
                        low_d     = rx_q1[3:0];
                        low_er_d  = er;
                        idle_ph_d = 1'b0;
                        state_d   = ST_HIGH;
                    end else begin
                        // Half-rate idle strobe so the MAC sees dv low after a frame.
                        idle_ph_d = !idle_ph_q;
                        if (idle_ph_q) begin
                            rxd_d    = 8'h00;
                            out_dv_d = 1'b0;
                            out_er_d = 1'b0;
                            clk_en_d = 1'b1;
                        end
                    end
                end
                ST_HIGH: begin
                    clk_en_d = 1'b1;
                    out_dv_d = 1'b1;
                    if (dv) begin
                        rxd_d    = {rx_q1[3:0], low_q};
                        out_er_d = low_er_q | er;
                        state_d  = ST_LOW;
                    end else begin
                        // Odd nibble count: flush the dangling nibble flagged as an error.
                        rxd_d     = {4'h0, low_q};
                        out_er_d  = 1'b1;
                        idle_ph_d = 1'b0;
                        state_d   = ST_IDLE;
                    end
                end
                ST_LOW: begin
                    if (dv) begin
                        low_d    = rx_q1[3:0];
                        low_er_d = er;
                        state_d  = ST_HIGH;
                    end else begin
                        idle_ph_d = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        link_d = link_q;
        if (!qual) begin
            cnt_d = 4'd0;
        end else if (cnt_q != 4'd0 && rx_q1[3:0] == cand_q) begin
            if (cnt_q < FILT) begin
                cnt_d = cnt_q + 4'd1;
            end
        end else begin
            cand_d = rx_q1[3:0];
            cnt_d  = 4'd1;
        end
        if (qual && cnt_d >= FILT) begin
            link_d = rx_q1[3:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gig_q     <= 1'b1;
            state_q   <= ST_IDLE;
            low_q     <= 4'h0;
            low_er_q  <= 1'b0;
            idle_ph_q <= 1'b0;
            rxd_q     <= 8'h00;
            out_dv_q  <= 1'b0;
            out_er_q  <= 1'b0;
            clk_en_q  <= 1'b0;
            cand_q    <= 4'h0;
            cnt_q     <= 4'd0;
            link_q    <= 4'h0;
        end else begin
            gig_q     <= gig_d;
            state_q   <= state_d;
            low_q     <= low_d;
            low_er_q  <= low_er_d;
            idle_ph_q <= idle_ph_d;
            rxd_q     <= rxd_d;
            out_dv_q  <= out_dv_d;
            out_er_q  <= out_er_d;
            clk_en_q  <= clk_en_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            link_q    <= link_d;
        end
    end

    assign gmii_rxd    = rxd_q;
    assign gmii_rx_dv  = out_dv_q;
    assign gmii_rx_er  = out_er_q;
    assign gmii_clk_en = clk_en_q;
    assign link_up     = link_q[0];
    assign link_speed  = link_q[2:1];
    assign link_duplex = link_q[3];

`ifdef RGMII_RX_DECODE_STATS_EN
    logic [15:0] frame_cnt_q, err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 16'h0000;
            err_cnt_q   <= 16'h0000;
        end else begin
            if (out_dv_q && !out_dv_d && frame_cnt_q != 16'hFFFF) begin
                frame_cnt_q <= frame_cnt_q + 16'h0001;
            end
            if (clk_en_d && out_er_d && err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'h0001;
            end
        end
    end

    assign frame_count = frame_cnt_q;
    assign error_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_rgmii_rx_decode.sv
// Self-checking bench for rgmii_rx_decode: strobed bytes are matched against a scoreboard queue,
// timing and status behaviour are checked inline by each scenario task.
module tb_rgmii_rx_decode;

    logic       clk;
    logic       rst_n;
    logic [4:0] rx_q1;
    logic [4:0] rx_q2;
    logic [1:0] speed;
    logic [7:0] gmii_rxd;
    logic       gmii_rx_dv;
    logic       gmii_rx_er;
    logic       gmii_clk_en;
    logic       link_up;
    logic [1:0] link_speed;
    logic       link_duplex;

    int errors = 0;
    int checks = 0;
    logic [9:0] exp_q[$];

    rgmii_rx_decode #(.STATUS_FILTER(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_q1      (rx_q1),
        .rx_q2      (rx_q2),
        .speed      (speed),
        .gmii_rxd   (gmii_rxd),
        .gmii_rx_dv (gmii_rx_dv),
        .gmii_rx_er (gmii_rx_er),
        .gmii_clk_en(gmii_clk_en),
        .link_up    (link_up),
        .link_speed (link_speed),
        .link_duplex(link_duplex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every strobe carrying dv or er must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [9:0] e;
        if (rst_n && gmii_clk_en && (gmii_rx_dv || gmii_rx_er)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe got rxd=%h dv=%b er=%b expected none",
                         gmii_rxd, gmii_rx_dv, gmii_rx_er);
            end else begin
                e = exp_q.pop_front();
                if ({gmii_rxd, gmii_rx_dv, gmii_rx_er} !== e) begin
                    errors++;
                    $display("FAIL strobe_byte got rxd=%h dv=%b er=%b expected rxd=%h dv=%b er=%b",
                             gmii_rxd, gmii_rx_dv, gmii_rx_er, e[9:2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    task automatic step(input logic [4:0] a, input logic [4:0] b);
        rx_q1 = a;
        rx_q2 = b;
        @(posedge clk);
        #1;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drained got %0d pending expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        speed = 2'b10;
        rx_q1 = 5'h00;
        rx_q2 = 5'h00;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_clk_en} !== 11'h0) begin
            errors++;
            $display("FAIL reset_gmii got %h expected 0",
                     {gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_clk_en});
        end
        checks++;
        if ({link_up, link_speed, link_duplex} !== 4'h0) begin
            errors++;
            $display("FAIL reset_link got %h expected 0", {link_up, link_speed, link_duplex});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_gig();
        speed = 2'b10;
        repeat (2) step(5'h00, 5'h00);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back({8'hA5, 1'b1, 1'b0});
            step(5'h15, 5'h1A);
            checks++;
            if (gmii_clk_en !== 1'b1 || gmii_rxd !== 8'hA5) begin
                errors++;
                $display("FAIL gig_latency cycle %0d got en=%b rxd=%h expected en=1 rxd=a5",
                         i, gmii_clk_en, gmii_rxd);
            end
        end
        // Carrier extension: dv low, er high, data passed through.
        exp_q.push_back({8'h3F, 1'b0, 1'b1});
        step(5'h0F, 5'h13);
        step(5'h00, 5'h00);
        checks++;
        if (gmii_clk_en !== 1'b1 || gmii_rx_dv !== 1'b0 || gmii_rx_er !== 1'b0) begin
            errors++;
            $display("FAIL gig_idle got en=%b dv=%b er=%b expected en=1 dv=0 er=0",
                     gmii_clk_en, gmii_rx_dv, gmii_rx_er);
        end
        step(5'h00, 5'h00);
        check_drained("gig");
    endtask

    task automatic test_slow_frame();
        logic [3:0] nibs [6];
        int strobes;
        logic prev_en;
        bit found;
        nibs = '{4'h5, 4'h5, 4'h5, 4'h5, 4'hD, 4'h5};
        speed = 2'b01;
        repeat (3) step(5'h00, 5'h00);
        exp_q.push_back({8'h55, 1'b1, 1'b0});
        exp_q.push_back({8'h55, 1'b1, 1'b0});
        exp_q.push_back({8'h5D, 1'b1, 1'b0});
        strobes = 0;
        prev_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step({1'b1, nibs[i]}, {1'b1, nibs[i]});
            checks++;
            if (prev_en && gmii_clk_en) begin
                errors++;
                $display("FAIL slow_spacing nibble %0d got back-to-back strobes expected gap", i);
            end
            prev_en = gmii_clk_en;
            if (gmii_clk_en) strobes++;
        end
        checks++;
        if (strobes != 3) begin
            errors++;
            $display("FAIL slow_strobe_count got %0d expected 3", strobes);
        end
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(5'h00, 5'h00);
            if (!found && gmii_clk_en) begin
                found = 1'b1;
                checks++;
                if (gmii_rx_dv !== 1'b0 || gmii_rx_er !== 1'b0) begin
                    errors++;
                    $display("FAIL slow_end_strobe got dv=%b er=%b expected dv=0 er=0",
                             gmii_rx_dv, gmii_rx_er);
                end
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL slow_end_strobe got none expected strobe within 4 clocks");
        end
        check_drained("slow_frame");
    endtask

    task automatic test_odd_nibbles();
        speed = 2'b01;
        repeat (2) step(5'h00, 5'h00);
        exp_q.push_back({8'hBA, 1'b1, 1'b0});
        exp_q.push_back({8'h0C, 1'b1, 1'b1});
        step(5'h1A, 5'h1A);
        step(5'h1B, 5'h1B);
        step(5'h1C, 5'h1C);
        step(5'h00, 5'h00);
        checks++;
        if (gmii_clk_en !== 1'b1 || gmii_rxd !== 8'h0C || gmii_rx_er !== 1'b1) begin
            errors++;
            $display("FAIL odd_flush got en=%b rxd=%h er=%b expected en=1 rxd=0c er=1",
                     gmii_clk_en, gmii_rxd, gmii_rx_er);
        end
        repeat (3) step(5'h00, 5'h00);
        check_drained("odd");
    endtask

    task automatic test_status();
        logic [4:0] seq [5];
        seq = '{5'h0D, 5'h0D, 5'h0C, 5'h0D, 5'h0D};
        for (int i = 0; i < 5; i++) begin
            step(seq[i], seq[i]);
            checks++;
            if (link_up !== 1'b0) begin
                errors++;
                $display("FAIL status_early sample %0d got link_up=%b expected 0", i, link_up);
            end
        end
        step(5'h0D, 5'h0D);
        checks++;
        if ({link_up, link_speed, link_duplex} !== {1'b1, 2'b10, 1'b1}) begin
            errors++;
            $display("FAIL status_latch got up=%b spd=%b dup=%b expected up=1 spd=10 dup=1",
                     link_up, link_speed, link_duplex);
        end
        step(5'h0C, 5'h0C);
        step(5'h0D, 5'h0D);
        checks++;
        if ({link_up, link_speed, link_duplex} !== {1'b1, 2'b10, 1'b1}) begin
            errors++;
            $display("FAIL status_glitch got up=%b spd=%b dup=%b expected up=1 spd=10 dup=1",
                     link_up, link_speed, link_duplex);
        end
    endtask

    task automatic test_speed_switch();
        logic prev_en;
        speed = 2'b10;
        repeat (2) step(5'h00, 5'h00);
        for (int i = 0; i < 6; i++) begin
            if (i == 2) speed = 2'b01;
            exp_q.push_back({8'hA5, 1'b1, 1'b0});
            step(5'h15, 5'h1A);
            checks++;
            if (gmii_clk_en !== 1'b1) begin
                errors++;
                $display("FAIL switch_gig_en cycle %0d got %b expected 1", i, gmii_clk_en);
            end
        end
        step(5'h00, 5'h00);
        checks++;
        if (gmii_clk_en !== 1'b1 || gmii_rx_dv !== 1'b0) begin
            errors++;
            $display("FAIL switch_frame_end got en=%b dv=%b expected en=1 dv=0",
                     gmii_clk_en, gmii_rx_dv);
        end
        exp_q.push_back({8'h21, 1'b1, 1'b0});
        exp_q.push_back({8'h43, 1'b1, 1'b0});
        prev_en = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            step({1'b1, 4'(n)}, {1'b1, 4'(n)});
            checks++;
            if (gmii_clk_en !== ((n % 2) == 0)) begin
                errors++;
                $display("FAIL switch_slow_en nibble %0d got %b expected %b",
                         n, gmii_clk_en, (n % 2) == 0);
            end
        end
        repeat (3) step(5'h00, 5'h00);
        check_drained("switch");
    endtask

    task automatic test_reset_mid();
        speed = 2'b01;
        repeat (3) step(5'h0D, 5'h0D);
        checks++;
        if (link_up !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_link got %b expected 1", link_up);
        end
        step(5'h17, 5'h17);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_clk_en, link_up, link_speed, link_duplex}
            !== 15'h0) begin
            errors++;
            $display("FAIL rst_async got %h expected 0",
                     {gmii_rxd, gmii_rx_dv, gmii_rx_er, gmii_clk_en, link_up, link_speed,
                      link_duplex});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) step(5'h00, 5'h00);
        exp_q.push_back({8'h98, 1'b1, 1'b0});
        step(5'h18, 5'h18);
        step(5'h19, 5'h19);
        repeat (3) step(5'h00, 5'h00);
        check_drained("rst_mid");
    endtask

    initial begin
        test_reset();
        test_gig();
        test_slow_frame();
        test_odd_nibbles();
        test_status();
        test_speed_switch();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rgmii_rx_decode.md
Name: rgmii_rx_decode

Overview:
- Consumes the 5-bit-wide (RXD[3:0] + RX_CTL) rising/falling sample pairs produced by the source-synchronous DDR input stage and rebuilds a GMII-style byte stream.
- Handles 1000M (one byte per clock) and 10/100M (nibble pairing, byte strobe every second clock).
- Decodes RGMII in-band link status during inter-frame gaps.
- Sits between the DDR capture stage and the MAC receive path, clocked by the recovered RX clock.

Parameters:
- STATUS_FILTER, 3: number of consecutive identical in-band status samples required before link status outputs update; legal range 1..15.

Ports:
- clk  input  1  recovered RX clock, same clock as the DDR capture outputs
- rst_n  input  1  reset, asynchronous, active-low
- rx_q1  input  5  rising-edge sample: [3:0] RXD, [4] RX_CTL (= RX_DV)
- rx_q2  input  5  falling-edge sample: [3:0] RXD, [4] RX_CTL (= RX_DV xor RX_ER)
- speed  input  2  00 = 10M, 01 = 100M, 10/11 = 1000M
- gmii_rxd  output  8  reconstructed byte
- gmii_rx_dv  output  1  data valid
- gmii_rx_er  output  1  receive error
- gmii_clk_en  output  1  byte strobe; outputs are meaningful only when high
- link_up  output  1  in-band link status
- link_speed  output  2  in-band speed code
- link_duplex  output  1  in-band duplex (1 = full)

Behaviour:
- Reset (rst_n low, async): all outputs 0, FSM = IDLE, nibble register 0, filter counter 0, active speed latched = 1000M on release.
- Per-cycle decode: dv = rx_q1[4]; er = rx_q1[4] ^ rx_q2[4].
- Speed latch: `speed` is sampled into the active mode only while FSM = IDLE and dv = 0. A change mid-frame is deferred until the frame ends.
- 1000M mode:
  - gmii_rxd = {rx_q2[3:0], rx_q1[3:0]}; gmii_rx_dv = dv; gmii_rx_er = er; gmii_clk_en = 1 every cycle.
  - Latency: 1 clock, registered.
  - dv = 0 with er = 1 (carrier extension / false carrier) is passed through as dv = 0, er = 1 with data.
- 10/100M mode: only rx_q1[3:0] is used. FSM states and transitions:
  - IDLE: on dv = 1, store nibble as low, go to HIGH.
  - HIGH: on dv = 1, emit byte {nibble, low}; dv = 1; er = OR of both nibble er flags; gmii_clk_en = 1 for 1 cycle; go to LOW.
  - HIGH, dv = 0 (odd nibble count): emit {4'h0, low} with dv = 1, er = 1, clk_en = 1; go to IDLE.
  - LOW: on dv = 1, store low nibble, go to HIGH; on dv = 0, go to IDLE.
  - gmii_clk_en pulses at most every 2nd clock during a frame.
  - In IDLE, a one-cycle clk_en pulse is issued every 2nd clock carrying dv = 0, er = 0, so downstream sees the frame end.
  - Outputs hold between strobes.
- In-band status: sampled only when dv = 0 and er = 0, in any mode.
  - Status word: link = rx_q1[0], speed = rx_q1[2:1], duplex = rx_q1[3].
  - Latched to the outputs once the same 4-bit value has been seen STATUS_FILTER consecutive qualifying cycles.
  - A non-qualifying cycle (dv = 1 or er = 1) resets the filter counter to 0; the latched value is retained.
- Reset mid-frame: immediate return to IDLE; the partial byte is discarded and no strobe is issued.

Optional Feature:
- Macro RGMII_RX_DECODE_STATS_EN.
- When defined, the block adds two output ports:
  - frame_count (16): increments on each dv 1->0 transition at the output.
  - error_count (16): increments on each emitted byte with er = 1.
- Both counters saturate at 16'hFFFF and reset to 0.
- When the macro is undefined, the ports and counters are absent.

Test Plan:
- 1000M, q1 = 5'h15/q2 = 5'h1A steady for 8 clocks → gmii_rxd = 8'hA5, dv = 1, er = 0, clk_en = 1 every cycle, 1-cycle latency.
- 100M, frame of nibbles 5,5,5,5,D,5 then dv = 0 → bytes 0x55, 0x55, 0x5D, each with dv = 1 and one clk_en per 2 clocks; then a strobe with dv = 0.
- 100M, 3 nibbles A,B,C then dv = 0 → bytes 0xBA (er = 0), then 0x0C with er = 1.
- Idle with q1 = q2 = 5'h0D, STATUS_FILTER = 3 → link_up = 1, link_speed = 2'b10, link_duplex = 1 after exactly the 3rd sample; a single glitched sample of 0x0C resets the filter and leaves the outputs unchanged.
- speed changed 1000M→100M mid-frame → 1000M decode continues until dv falls; 100M pairing starts on the next frame.
- rst_n asserted during the HIGH state → all outputs 0 asynchronously; first byte after release is correctly paired.
